// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback
// and a 2-entry FIFO of long-latency aux writes, with a starvation stall.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        aux_valid,
  input  logic [4:0]  aux_addr,
  input  logic [31:0] aux_data,
  output logic        aux_ready,
  input  logic [4:0]  r1_addr,
  input  logic [4:0]  r2_addr,
  output logic        hazard,
  output logic        stall_pipe,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FORCE
  } state_t;

  state_t        state, state_next;
  logic [SW-1:0] starve, starve_next, starve_inc;

  logic [4:0]  mem_addr [2];
  logic [31:0] mem_data [2];
  logic [1:0]  vld;
  logic        wr_ptr, rd_ptr;
  logic        rf_aux;

  logic [1:0]  count, count_next;
  logic        push, pop, wb_ok;
  logic        issue_we, issue_aux;
  logic [4:0]  issue_addr;
  logic [31:0] issue_data;

  assign count = {1'b0, vld[0]} + {1'b0, vld[1]};
  assign aux_ready = !rst && (count != 2'd2);
  assign push = aux_valid && aux_ready && (aux_addr != 5'd0);
  assign wb_ok = wb_we && (wb_addr != 5'd0);
  assign starve_inc = starve + 1'b1;
  assign count_next = count + {1'b0, push} - {1'b0, pop};

  always_comb begin
    pop        = 1'b0;
    issue_we   = 1'b0;
    issue_aux  = 1'b0;
    issue_addr = 5'd0;
    issue_data = 32'd0;
    if (stall_pipe || (!wb_ok && vld[rd_ptr])) begin
      pop        = vld[rd_ptr];
      issue_we   = vld[rd_ptr];
      issue_aux  = 1'b1;
      issue_addr = mem_addr[rd_ptr];
      issue_data = mem_data[rd_ptr];
    end else if (wb_ok) begin
      issue_we   = 1'b1;
      issue_addr = wb_addr;
      issue_data = wb_data;
    end
  end

  always_comb begin
    state_next  = state;
    starve_next = starve;
    unique case (state)
      IDLE: begin
        starve_next = '0;
        if (push) state_next = WAIT;
      end
      WAIT: begin
        if (pop) begin
          starve_next = '0;
          if (count_next == 2'd0) state_next = IDLE;
        end else begin
          starve_next = starve_inc;
          if (starve_inc == SW'(STARVE_LIMIT)) state_next = FORCE;
        end
      end
      FORCE: begin
        starve_next = '0;
        state_next  = (count_next == 2'd0) ? IDLE : WAIT;
      end
      default: begin
        starve_next = '0;
        state_next  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve     <= '0;
      vld        <= 2'b00;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      stall_pipe <= 1'b0;
      rf_we      <= 1'b0;
      rf_aux     <= 1'b0;
      rf_addr    <= 5'd0;
      rf_data    <= 32'd0;
    end else begin
      state      <= state_next;
      starve     <= starve_next;
      stall_pipe <= (state_next == FORCE);
      rf_we      <= issue_we;
      rf_aux     <= issue_we && issue_aux;
      rf_addr    <= issue_addr;
      rf_data    <= issue_data;
      if (push) begin
        mem_addr[wr_ptr] <= aux_addr;
        mem_data[wr_ptr] <= aux_data;
        vld[wr_ptr]      <= 1'b1;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= ~rd_ptr;
      end
    end
  end

  // The aux write on the port still counts as outstanding until it lands.
  function automatic logic hit(input logic [4:0] a);
    hit = (a != 5'd0) &&
          ((vld[0] && mem_addr[0] == a) ||
           (vld[1] && mem_addr[1] == a) ||
           (rf_we && rf_aux && rf_addr == a));
  endfunction

  assign hazard = hit(r1_addr) || hit(r2_addr);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: WB vector table plus scripted aux,
// starvation, full-FIFO, address-0 and mid-operation reset sequences.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we, aux_valid, aux_ready;
  logic [4:0]  wb_addr, aux_addr, r1_addr, r2_addr, rf_addr;
  logic [31:0] wb_data, aux_data, rf_data;
  logic        hazard, stall_pipe, rf_we;

  regfile_wb_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .aux_valid(aux_valid), .aux_addr(aux_addr), .aux_data(aux_data),
    .aux_ready(aux_ready),
    .r1_addr(r1_addr), .r2_addr(r2_addr),
    .hazard(hazard), .stall_pipe(stall_pipe),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          c;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
    logic [4:0]  r1;
    logic        wr;
  } vec_t;
  vec_t tbl[6];

  int checks = 0;
  int errors = 0;
  logic rst_v = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic expect_wr(input int c, input logic [4:0] a,
                           input logic [31:0] d);
    exp_t e;
    e.c = c;
    e.a = a;
    e.d = d;
    q.push_back(e);
  endtask

  task automatic drive(input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic av,
                       input logic [4:0] aa, input logic [31:0] ad,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    rst = rst_v;
    wb_we = we; wb_addr = wa; wb_data = wd;
    aux_valid = av; aux_addr = aa; aux_data = ad;
    r1_addr = r1; r2_addr = r2;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Scoreboard: every rf write must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rf_unexpected: got write %0d=%h, expected none (cycle %0d)",
                 rf_addr, rf_data, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rf_addr", 32'(rf_addr), 32'(e.a));
        chk("rf_data", rf_data, e.d);
        chk("rf_cycle", cyc, e.c);
      end
    end else if (q.size() > 0 && q[0].c < cyc) begin
      checks++;
      errors++;
      $display("FAIL rf_missing: got no write, expected %0d=%h at cycle %0d",
               q[0].a, q[0].d, q[0].c);
      void'(q.pop_front());
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    tbl[0] = '{1'b1, 5'd5,  32'hA5A5A5A5, 5'd0,  1'b1};
    tbl[1] = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd5,  1'b0};
    tbl[2] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd0,  1'b1};
    tbl[3] = '{1'b1, 5'd1,  32'h00000001, 5'd31, 1'b1};
    tbl[4] = '{1'b0, 5'd9,  32'h12345678, 5'd1,  1'b0};
    tbl[5] = '{1'b1, 5'd9,  32'h00000000, 5'd0,  1'b1};

    rst_v = 1'b1;
    idle(1);
    chk("ready_in_rst", 32'(aux_ready), 0);
    idle(1);
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_rf_addr", 32'(rf_addr), 0);
    chk("rst_rf_data", rf_data, 0);
    chk("rst_stall", 32'(stall_pipe), 0);
    rst_v = 1'b0;
    idle(1);
    chk("rst_ready", 32'(aux_ready), 1);
    chk("rst_hazard", 32'(hazard), 0);

    // WB-only vectors; WB-origin writes never raise hazard.
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].we, tbl[i].a, tbl[i].d, 0, 0, 0, tbl[i].r1, 0);
      if (tbl[i].wr) expect_wr(cyc + 1, tbl[i].a, tbl[i].d);
      chk("wb_hazard", 32'(hazard), 0);
      chk("wb_stall", 32'(stall_pipe), 0);
    end
    idle(2);

    // Aux only: two-cycle latency, hazard until the write lands.
    drive(0, 0, 0, 1, 7, 32'h11, 7, 0);
    n = cyc;
    expect_wr(n + 2, 7, 32'h11);
    chk("aux_ready", 32'(aux_ready), 1);
    chk("aux_haz0", 32'(hazard), 0);
    drive(0, 0, 0, 0, 0, 0, 7, 0);
    chk("aux_haz1", 32'(hazard), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 7);
    chk("aux_haz2", 32'(hazard), 1);
    drive(0, 0, 0, 0, 0, 0, 7, 0);
    chk("aux_haz3", 32'(hazard), 0);
    idle(1);

    // Starvation: three blocked cycles, then one stall cycle.
    drive(1, 10, 32'h100, 1, 3, 32'h33, 0, 0);
    n = cyc;
    expect_wr(n + 1, 10, 32'h100);
    chk("starve_stall0", 32'(stall_pipe), 0);
    drive(1, 11, 32'h101, 0, 0, 0, 0, 0);
    expect_wr(n + 2, 11, 32'h101);
    chk("starve_stall1", 32'(stall_pipe), 0);
    drive(1, 12, 32'h102, 0, 0, 0, 0, 0);
    expect_wr(n + 3, 12, 32'h102);
    chk("starve_stall2", 32'(stall_pipe), 0);
    drive(1, 13, 32'h103, 0, 0, 0, 3, 0);
    expect_wr(n + 4, 13, 32'h103);
    chk("starve_stall3", 32'(stall_pipe), 0);
    chk("starve_haz", 32'(hazard), 1);
    drive(1, 14, 32'h104, 0, 0, 0, 0, 0);
    expect_wr(n + 5, 3, 32'h33);
    chk("starve_stall4", 32'(stall_pipe), 1);
    drive(1, 14, 32'h104, 0, 0, 0, 0, 0);
    expect_wr(n + 6, 14, 32'h104);
    chk("starve_stall5", 32'(stall_pipe), 0);
    idle(2);

    // Full FIFO: third aux write held until the cycle after the first pop.
    drive(1, 1, 32'h201, 1, 20, 32'h20, 0, 0);
    n = cyc;
    expect_wr(n + 1, 1, 32'h201);
    chk("full_rdy0", 32'(aux_ready), 1);
    drive(1, 2, 32'h202, 1, 21, 32'h21, 0, 0);
    expect_wr(n + 2, 2, 32'h202);
    chk("full_rdy1", 32'(aux_ready), 1);
    drive(1, 4, 32'h204, 1, 22, 32'h22, 21, 0);
    expect_wr(n + 3, 4, 32'h204);
    chk("full_rdy2", 32'(aux_ready), 0);
    chk("full_haz", 32'(hazard), 1);
    drive(0, 0, 0, 1, 22, 32'h22, 0, 0);
    expect_wr(n + 4, 20, 32'h20);
    chk("full_rdy3", 32'(aux_ready), 0);
    drive(0, 0, 0, 1, 22, 32'h22, 0, 0);
    expect_wr(n + 5, 21, 32'h21);
    chk("full_rdy4", 32'(aux_ready), 1);
    chk("full_stall", 32'(stall_pipe), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_wr(n + 6, 22, 32'h22);
    idle(2);

    // Address 0: handshake only, nothing buffered or written.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'hBAD0 + 32'(i), 1, 0, 32'hBAD1, 0, 0);
      chk("zero_ready", 32'(aux_ready), 1);
      chk("zero_haz", 32'(hazard), 0);
    end
    idle(3);

    // Reset with two entries buffered drops them.
    drive(1, 2, 32'h302, 1, 25, 32'h25, 0, 0);
    n = cyc;
    expect_wr(n + 1, 2, 32'h302);
    drive(1, 3, 32'h303, 1, 26, 32'h26, 0, 0);
    expect_wr(n + 2, 3, 32'h303);
    chk("mid_rdy", 32'(aux_ready), 1);
    rst_v = 1'b1;
    idle(1);
    chk("mid_rdy_rst", 32'(aux_ready), 0);
    rst_v = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 25, 26);
    chk("mid_rf_we", 32'(rf_we), 0);
    chk("mid_haz", 32'(hazard), 0);
    chk("mid_rdy_after", 32'(aux_ready), 1);
    chk("mid_stall", 32'(stall_pipe), 0);
    idle(5);

    chk("sb_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: consecutive cycles a buffered aux write may wait before the pipeline is forced to stall.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 wb_we  in  1  pipeline writeback write request.
REQ-005 wb_addr  in  5  pipeline writeback register address.
REQ-006 wb_data  in  32  pipeline writeback data.
REQ-007 aux_valid  in  1  long-latency unit write request (valid/ready).
REQ-008 aux_addr  in  5  aux write address.
REQ-009 aux_data  in  32  aux write data.
REQ-010 aux_ready  out  1  aux write accepted this cycle when high with aux_valid.
REQ-011 r1_addr, r2_addr  in  5 each  decode-stage read addresses for hazard check.
REQ-012 hazard  out  1  a read address matches an outstanding aux write.
REQ-013 stall_pipe  out  1  registered; freezes pipeline for one cycle to free the write port.
REQ-014 rf_we, rf_addr, rf_data  out  1/5/32  registered single write port to the register file.

Function
REQ-015 A 2-entry in-order FIFO SHALL buffer aux writes; aux_ready = (count < 2), and aux_ready is 0 while rst is high.
REQ-016 Push on aux_valid && aux_ready; aux writes to address 0 SHALL be acknowledged but not pushed.
REQ-017 Port priority per cycle: if stall_pipe=1, issue FIFO head; else if wb_we && wb_addr != 0, issue WB; else if FIFO nonempty, issue head; else no write.
REQ-018 WB requests to address 0 SHALL be discarded (rf_we stays 0 for them).
REQ-019 While stall_pipe=1, wb_* inputs SHALL be ignored; the pipeline re-presents them next cycle.
REQ-020 The issued write SHALL appear on rf_we/rf_addr/rf_data one cycle after the issue decision; minimum aux latency is accept to rf_we = 2 cycles (no bypass around the FIFO).
REQ-021 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo 2.
REQ-022 The FSM SHALL have states IDLE (FIFO empty), WAIT (nonempty, head blocked by WB), and FORCE (stall_pipe=1).
REQ-023 The starve counter SHALL increment each cycle in WAIT when the head is not issued, and clear on any pop or on entering IDLE.
REQ-024 Transitions: IDLE->WAIT on push; WAIT->IDLE when the last entry pops; WAIT->FORCE when the counter reaches STARVE_LIMIT; FORCE (exactly 1 cycle, head popped) -> IDLE if the FIFO is then empty, else WAIT with the counter cleared.
REQ-025 hazard SHALL be combinational: 1 when r1_addr or r2_addr (nonzero) equals the address of any valid FIFO entry, or equals rf_addr while rf_we=1 and that write originated from aux.
REQ-026 Writes SHALL never be coalesced or reordered: the FIFO drains in push order, and WB and aux writes to the same address land in issue order.

Reset
REQ-027 On rst: FIFO count, pointers, and starve counter SHALL be 0, the state IDLE, and rf_we, rf_addr, rf_data, and stall_pipe 0.
REQ-028 Reset mid-operation SHALL drop all buffered aux writes with no rf write issued for them; hazard is 0 in the first cycle after reset.

Verification
REQ-029 Idle WB: wb_we=1, addr=5, data=0xA5A5A5A5 -> next cycle rf_we=1, rf_addr=5, rf_data=0xA5A5A5A5.
REQ-030 Aux only: push addr=7, data=0x11 with wb_we=0 -> rf_we=1 for addr 7 two cycles after accept; hazard=1 for r1_addr=7 until that write cycle ends.
REQ-031 Starvation: push aux addr=3 with wb_we=1 every cycle, STARVE_LIMIT=3 -> stall_pipe=1 for exactly one cycle after 3 blocked cycles, and the aux write to 3 is issued in that cycle.
REQ-032 Full FIFO: two pushes while WB is busy -> aux_ready=0; a third aux_valid is held, and is accepted in the cycle after the first pop.
REQ-033 Address 0: WB and aux writes to $0 -> rf_we never asserted and FIFO count unchanged; aux still handshakes.
REQ-034 Reset with 2 entries buffered -> after rst, count=0, aux_ready=1, no rf_we for the dropped entries.
